// File: rtl/mac_frame_acc.sv
// mac_frame_acc: four-stage multi-lane multiply-accumulate over frames.
// Each accepted beat contributes the sum of LANES signed products a[i]*b[i].
// Beats are summed until an eof beat, then the frame total, its beat count and
// a sticky overflow flag are presented on a valid/ready output.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input beat handshake (in_ready = global advance)
//   a, b                  packed signed lane operands
//   eof                   accepted beat is the last of its frame
//   out_valid/out_ready   frame result handshake
//   result                signed frame sum (saturated or wrapped)
//   frame_len             beats in the reported frame (saturating)
//   overflow              accumulator overflowed during the reported frame
module mac_frame_acc #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned A_WIDTH   = 8,
   parameter int unsigned B_WIDTH   = 8,
   parameter int unsigned OUT_WIDTH = 20,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*A_WIDTH-1:0]     a,
   input  logic [LANES*B_WIDTH-1:0]     b,
   input  logic                         eof,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_WIDTH-1:0]  result,
   output logic [LEN_WIDTH-1:0]         frame_len,
   output logic                         overflow
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;
   localparam int unsigned SW = PW + $clog2(LANES);
   localparam int unsigned EW = OUT_WIDTH + 1;
   localparam logic signed [OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Accumulator must hold at least one full beat sum without loss.
   if (OUT_WIDTH < SW) begin : g_width_check
      $error("mac_frame_acc: OUT_WIDTH too small for A_WIDTH+B_WIDTH+clog2(LANES)");
   end

   logic advance;
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;

   // S0: input register
   logic                     v0, e0;
   logic [LANES*A_WIDTH-1:0] a0;
   logic [LANES*B_WIDTH-1:0] b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v0 <= 1'b0;
         e0 <= 1'b0;
         a0 <= '0;
         b0 <= '0;
      end else if (advance) begin
         v0 <= in_valid;
         e0 <= in_valid && eof;
         a0 <= a;
         b0 <= b;
      end
   end

   // S1: full-width signed per-lane products
   logic                 v1, e1;
   logic signed [PW-1:0] p_c [LANES];
   logic signed [PW-1:0] p1  [LANES];

   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         p_c[i] = PW'($signed(a0[i*A_WIDTH +: A_WIDTH])) * PW'($signed(b0[i*B_WIDTH +: B_WIDTH]));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
         for (int i = 0; i < int'(LANES); i++) p1[i] <= '0;
      end else if (advance) begin
         v1 <= v0;
         e1 <= e0;
         for (int i = 0; i < int'(LANES); i++) p1[i] <= p_c[i];
      end
   end

   // S2: sign-extended sum of all lanes
   logic                 v2, e2;
   logic signed [SW-1:0] sum_c, s2;

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(LANES); i++) sum_c = sum_c + SW'(p1[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2 <= 1'b0;
         e2 <= 1'b0;
         s2 <= '0;
      end else if (advance) begin
         v2 <= v1;
         e2 <= e1;
         s2 <= sum_c;
      end
   end

   // S3: frame accumulation; 'first' marks that the next valid beat opens a frame
   logic signed [OUT_WIDTH-1:0] acc, acc_c;
   logic [LEN_WIDTH-1:0]        cnt, cnt_c;
   logic                        flag, flag_c, first;
   logic signed [EW-1:0]        ext_c;
   logic                        ovf_c;

   always_comb begin
      ext_c  = EW'(acc) + EW'(s2);
      ovf_c  = ext_c[EW-1] != ext_c[EW-2];
      acc_c  = ext_c[OUT_WIDTH-1:0];
      cnt_c  = (&cnt) ? cnt : cnt + LEN_WIDTH'(1);
      flag_c = flag || ovf_c;
      if (first) begin
         acc_c  = OUT_WIDTH'(s2);
         cnt_c  = LEN_WIDTH'(1);
         flag_c = 1'b0;
      end else if (ovf_c && (SATURATE != 0)) begin
         acc_c = ext_c[EW-1] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= '0;
         cnt       <= '0;
         flag      <= 1'b0;
         first     <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         frame_len <= '0;
         overflow  <= 1'b0;
      end else begin
         if (advance && v2) begin
            acc   <= acc_c;
            cnt   <= cnt_c;
            flag  <= flag_c;
            first <= e2;
         end
         // A new result may replace the one being taken on the same edge.
         if (advance && v2 && e2) begin
            result    <= acc_c;
            frame_len <= cnt_c;
            overflow  <= flag_c;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_frame_acc.sv
// Bench for mac_frame_acc: three instances (default, 18-bit saturating,
// 18-bit wrapping) share one stimulus stream and are checked every cycle
// against a frame-level model, plus literal expectations for known frames.
module tb_mac_frame_acc;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, eof, out_ready;
   logic [31:0] a, b;
   logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
   logic signed [19:0] r0;
   logic signed [17:0] r1, r2;
   logic [15:0] fl0, fl1, fl2;

   mac_frame_acc dut0 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
      .a(a), .b(b), .eof(eof), .out_valid(ov0), .out_ready(out_ready),
      .result(r0), .frame_len(fl0), .overflow(of0));
   mac_frame_acc #(.OUT_WIDTH(18), .SATURATE(1)) dut1 (.clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .eof(eof), .out_valid(ov1),
      .out_ready(out_ready), .result(r1), .frame_len(fl1), .overflow(of1));
   mac_frame_acc #(.OUT_WIDTH(18), .SATURATE(0)) dut2 (.clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b), .eof(eof), .out_valid(ov2),
      .out_ready(out_ready), .result(r2), .frame_len(fl2), .overflow(of2));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   typedef struct packed {
      logic signed [31:0] r0, r1, r2;
      logic [15:0]        len;
      logic [2:0]         ov;
      logic signed [31:0] adv;   // advancing edges left before it is presented
   } exp_t;

   exp_t   pend[$];
   exp_t   cur, ne;
   bit     exp_ov;
   bit     in_frame;
   longint macc[3];
   bit     mflag[3];
   int     mcnt;
   int     frames_out;
   bit     madv, mo;
   longint ms;
   longint seen[$];

   function automatic longint beat_sum(input logic [31:0] av, input logic [31:0] bv);
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++)
         s += longint'($signed(av[i*8 +: 8])) * longint'($signed(bv[i*8 +: 8]));
      return s;
   endfunction

   function automatic longint fold(input longint acc, input longint s, input int w,
                                   input bit sat, output bit ov);
      longint t, mx, mn, span;
      span = longint'(1) << w;
      mx   = (longint'(1) << (w - 1)) - 1;
      mn   = -(longint'(1) << (w - 1));
      t    = acc + s;
      ov   = (t > mx) || (t < mn);
      if (ov) begin
         if (sat) t = (t > mx) ? mx : mn;
         else begin
            t = t & (span - 1);
            if (t > mx) t -= span;
         end
      end
      return t;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend.delete();
         exp_ov   = 1'b0;
         in_frame = 1'b0;
         mcnt     = 0;
         for (int c = 0; c < 3; c++) begin macc[c] = 0; mflag[c] = 1'b0; end
      end else begin
         madv = !(exp_ov && !out_ready);
         if (exp_ov && out_ready) begin
            exp_ov = 1'b0;
            frames_out++;
         end
         if (madv) begin
            foreach (pend[i]) pend[i].adv = pend[i].adv - 1;
            if (pend.size() > 0 && pend[0].adv == 0) begin
               cur    = pend.pop_front();
               exp_ov = 1'b1;
            end
            if (in_valid) begin
               ms = beat_sum(a, b);
               for (int c = 0; c < 3; c++) begin
                  if (!in_frame) begin
                     macc[c]  = ms;
                     mflag[c] = 1'b0;
                  end else begin
                     macc[c]  = fold(macc[c], ms, (c == 0) ? 20 : 18, c != 2, mo);
                     mflag[c] = mflag[c] | mo;
                  end
               end
               mcnt     = !in_frame ? 1 : ((mcnt < 65535) ? mcnt + 1 : mcnt);
               in_frame = 1'b1;
               if (eof) begin
                  ne.r0  = 32'(macc[0]);
                  ne.r1  = 32'(macc[1]);
                  ne.r2  = 32'(macc[2]);
                  ne.len = 16'(mcnt);
                  ne.ov  = {mflag[2], mflag[1], mflag[0]};
                  ne.adv = 3;
                  pend.push_back(ne);
                  in_frame = 1'b0;
               end
            end
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("in_ready", {ir2, ir1, ir0}, (exp_ov && !out_ready) ? 0 : 7);
         chk("out_valid", {ov2, ov1, ov0}, exp_ov ? 7 : 0);
         if (exp_ov) begin
            chk("result_w20", r0, longint'($signed(cur.r0)));
            chk("result_w18sat", r1, longint'($signed(cur.r1)));
            chk("result_w18wrap", r2, longint'($signed(cur.r2)));
            chk("frame_len_w20", fl0, cur.len);
            chk("frame_len_w18sat", fl1, cur.len);
            chk("frame_len_w18wrap", fl2, cur.len);
            chk("overflow", {of2, of1, of0}, cur.ov);
         end
         if (ov0 && out_ready) seen.push_back(r0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1 in_valid = 1'b0;
         eof = 1'b0;
      end
   endtask

   // Present one beat (same value on all lanes) and hold it until accepted.
   task automatic send(input logic [7:0] av, input logic [7:0] bv, input bit e);
      int k;
      bit r;
      a = {4{av}};
      b = {4{bv}};
      eof = e;
      in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         r = ir0;
         @(posedge clk);
         k++;
      end while (!r && k < 200);
      if (!r) chk("accept_timeout", 0, 1);
      #1 in_valid = 1'b0;
      eof = 1'b0;
   endtask

   // Called right after the eof beat's accepting edge T; result must appear after T+3.
   task automatic expect_frame(input string nm, input longint e0, input longint e1,
                               input longint e2, input longint len, input longint ovf);
      repeat (3) begin
         @(negedge clk);
         chk({nm, "_early"}, ov0, 0);
         @(posedge clk);
      end
      @(negedge clk);
      chk({nm, "_valid"}, {ov2, ov1, ov0}, 7);
      chk({nm, "_r0"}, r0, e0);
      chk({nm, "_r1"}, r1, e1);
      chk({nm, "_r2"}, r2, e2);
      chk({nm, "_len"}, fl0, len);
      chk({nm, "_ovf"}, {of2, of1, of0}, ovf);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid  = 1'b0;
      eof       = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      reset_n   = 1'b0;

      // Reset with random inputs
      repeat (4) begin
         @(posedge clk);
         #1 in_valid = 1'($urandom);
         a = $urandom;
         b = $urandom;
         eof = 1'($urandom);
         out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_out_valid", {ov2, ov1, ov0}, 0);
         chk("rst_result", r0, 0);
         chk("rst_frame_len", fl0, 0);
         chk("rst_overflow", {of2, of1, of0}, 0);
         chk("rst_in_ready", {ir2, ir1, ir0}, 7);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      eof = 1'b0;
      out_ready = 1'b1;
      reset_n = 1'b1;
      idle(2);

      // Three beats of 2*3 on every lane
      send(8'd2, 8'd3, 1'b0);
      send(8'd2, 8'd3, 1'b0);
      send(8'd2, 8'd3, 1'b1);
      expect_frame("three_beat", 72, 72, 72, 3, 0);
      idle(2);

      // Single beat at the most negative operands
      send(8'h80, 8'h80, 1'b1);
      expect_frame("single_min", 65536, 65536, 65536, 1, 0);
      idle(2);

      // Two such beats overflow the 18-bit accumulators only
      send(8'h80, 8'h80, 1'b0);
      send(8'h80, 8'h80, 1'b1);
      expect_frame("sat_wrap", 131072, 131071, -131072, 2, 3'b110);
      idle(3);

      // Back-pressure with following frames queued behind the pending result
      seen.delete();
      out_ready = 1'b0;
      send(8'd1, 8'd1, 1'b1);
      send(8'd2, 8'd3, 1'b0);
      send(8'd2, 8'd3, 1'b1);
      send(8'd5, 8'd5, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", ir0, 0);
         chk("stall_out_valid", ov0, 1);
         chk("stall_result", r0, 4);
         @(posedge clk);
      end
      #1 out_ready = 1'b1;
      idle(10);
      chk("order_count", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("order_0", seen[0], 4);
         chk("order_1", seen[1], 48);
         chk("order_2", seen[2], 100);
      end

      // Reset in the middle of a frame discards it
      send(8'd3, 8'd3, 1'b0);
      send(8'd3, 8'd3, 1'b0);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      send(8'd1, 8'd1, 1'b1);
      expect_frame("after_reset", 4, 4, 4, 1, 0);
      idle(3);

      // Randomized traffic with random back-pressure
      repeat (3000) begin
         @(posedge clk);
         #1 in_valid = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 3) == 0) ? 32'h80808080 : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'h80808080 : $urandom;
         eof = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      eof = 1'b0;
      out_ready = 1'b1;
      idle(20);
      chk("frames_seen", frames_out > 200, 1);
      chk("drained", pend.size() + int'(exp_ov), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
